// File: rtl/logip_pkg.sv
// Shared constants and types for the SUMP response path: identify string,
// metadata tokens, device name and the response-state encoding.
package logip_pkg;

  localparam logic [31:0] SUMP_ID   = 32'h3141_4C53;  // "1ALS"
  localparam logic [39:0] DEV_NAME  = "logIP";
  localparam logic [31:0] PROTO_VER = 32'd2;

  localparam logic [7:0] TOK_NAME   = 8'h01;
  localparam logic [7:0] TOK_PROBES = 8'h20;
  localparam logic [7:0] TOK_MEM    = 8'h21;
  localparam logic [7:0] TOK_RATE   = 8'h23;
  localparam logic [7:0] TOK_PROTO  = 8'h24;
  localparam logic [7:0] TOK_END    = 8'h00;

  localparam int ID_LEN   = 4;
  localparam int META_LEN = 28;

  typedef enum logic [1:0] {IDLE, ID, META, SMPL} rsp_state_e;

  function automatic logic [7:0] id_byte(input logic [1:0] k);
    case (k)
      2'd0:    return SUMP_ID[31:24];
      2'd1:    return SUMP_ID[23:16];
      2'd2:    return SUMP_ID[15:8];
      default: return SUMP_ID[7:0];
    endcase
  endfunction

  function automatic logic [3:0] low_bit(input logic [3:0] m);
    return m & (~m + 4'd1);
  endfunction

  // Byte of the lowest enabled group still left in the mask.
  function automatic logic [7:0] grp_byte(input logic [31:0] w, input logic [3:0] m);
    if (m[0])      return w[7:0];
    else if (m[1]) return w[15:8];
    else if (m[2]) return w[23:16];
    else if (m[3]) return w[31:24];
    else           return 8'h00;
  endfunction

endpackage

// File: rtl/sump_resp_tx_if.sv
// Decoder/sampler-side strobes plus the byte stream toward the UART.
interface sump_resp_tx_if;
  logic        sft_rst_i;
  logic        id_i;
  logic        rd_meta_i;
  logic        xon_i;
  logic        xoff_i;
  logic [3:0]  grp_en_i;
  logic        smpl_vld_i;
  logic [31:0] smpl_i;
  logic        smpl_rdy_o;
  logic        tx_vld_o;
  logic [7:0]  tx_dat_o;
  logic        tx_rdy_i;
  logic        busy_o;

  modport master (
    input  sft_rst_i, id_i, rd_meta_i, xon_i, xoff_i,
    input  grp_en_i, smpl_vld_i, smpl_i, tx_rdy_i,
    output smpl_rdy_o, tx_vld_o, tx_dat_o, busy_o
  );

  modport slave (
    output sft_rst_i, id_i, rd_meta_i, xon_i, xoff_i,
    output grp_en_i, smpl_vld_i, smpl_i, tx_rdy_i,
    input  smpl_rdy_o, tx_vld_o, tx_dat_o, busy_o
  );
endinterface

// File: rtl/sump_meta_rom.sv
// Metadata response table: byte index -> byte, values big-endian.
module sump_meta_rom
  import logip_pkg::*;
#(
  parameter int unsigned NUM_PROBES = 32,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned MAX_RATE   = 100_000_000
) (
  input  logic [4:0] idx,
  output logic [7:0] dat
);

  localparam logic [31:0] PROBES    = 32'(NUM_PROBES);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
  localparam logic [31:0] RATE      = 32'(MAX_RATE);

  always_comb begin
    dat = TOK_END;
    case (idx)
      5'd0:  dat = TOK_NAME;
      5'd1:  dat = DEV_NAME[39:32];
      5'd2:  dat = DEV_NAME[31:24];
      5'd3:  dat = DEV_NAME[23:16];
      5'd4:  dat = DEV_NAME[15:8];
      5'd5:  dat = DEV_NAME[7:0];
      5'd6:  dat = TOK_END;
      5'd7:  dat = TOK_PROBES;
      5'd8:  dat = PROBES[31:24];
      5'd9:  dat = PROBES[23:16];
      5'd10: dat = PROBES[15:8];
      5'd11: dat = PROBES[7:0];
      5'd12: dat = TOK_MEM;
      5'd13: dat = MEM_BYTES[31:24];
      5'd14: dat = MEM_BYTES[23:16];
      5'd15: dat = MEM_BYTES[15:8];
      5'd16: dat = MEM_BYTES[7:0];
      5'd17: dat = TOK_RATE;
      5'd18: dat = RATE[31:24];
      5'd19: dat = RATE[23:16];
      5'd20: dat = RATE[15:8];
      5'd21: dat = RATE[7:0];
      5'd22: dat = TOK_PROTO;
      5'd23: dat = PROTO_VER[31:24];
      5'd24: dat = PROTO_VER[23:16];
      5'd25: dat = PROTO_VER[15:8];
      5'd26: dat = PROTO_VER[7:0];
      default: dat = TOK_END;
    endcase
  end

endmodule

// File: rtl/sump_resp_tx.sv
// SUMP response formatter: serialises identify, metadata and sample words
// into a valid/ready byte stream with XON/XOFF pause and soft reset.
module sump_resp_tx
  import logip_pkg::*;
#(
  parameter int unsigned NUM_PROBES = 32,
  parameter int unsigned MEM_DEPTH  = 4096,
  parameter int unsigned MAX_RATE   = 100_000_000
) (
  input  logic          clk_i,
  input  logic          rst_in,
  sump_resp_tx_if.master bus
);

  rsp_state_e  state;
  logic [4:0]  idx;
  logic        pend_id, pend_meta, paused, up;
  logic [31:0] smpl_q;
  logic [3:0]  msk;
  logic        tx_vld;
  logic [7:0]  tx_dat;

  logic        pause_nxt, xfer, req_id, req_meta, smpl_rdy, smpl_acc, last;
  logic [4:0]  nidx;
  logic [3:0]  msk_rem;
  logic [7:0]  rom_byte, seq_byte;

  // xoff wins over xon; the post-edge pause value gates raising a new byte.
  assign pause_nxt = bus.xoff_i | (paused & ~bus.xon_i);
  assign xfer      = tx_vld & bus.tx_rdy_i;
  assign req_id    = pend_id | bus.id_i;
  assign req_meta  = pend_meta | bus.rd_meta_i;
  assign smpl_rdy  = up & (state == IDLE) & ~pend_id & ~pend_meta & ~bus.sft_rst_i;
  assign smpl_acc  = bus.smpl_vld_i & smpl_rdy;

  assign nidx    = xfer ? idx + 5'd1 : idx;
  assign last    = ((state == ID)   && (idx == 5'(ID_LEN - 1))) ||
                   ((state == META) && (idx == 5'(META_LEN - 1)));
  assign msk_rem = xfer ? (msk & ~low_bit(msk)) : msk;

  sump_meta_rom #(
    .NUM_PROBES (NUM_PROBES),
    .MEM_DEPTH  (MEM_DEPTH),
    .MAX_RATE   (MAX_RATE)
  ) u_rom (
    .idx (nidx),
    .dat (rom_byte)
  );

  assign seq_byte = (state == ID) ? id_byte(nidx[1:0]) : rom_byte;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      idx       <= '0;
      pend_id   <= 1'b0;
      pend_meta <= 1'b0;
      paused    <= 1'b0;
      up        <= 1'b0;
      smpl_q    <= '0;
      msk       <= '0;
      tx_vld    <= 1'b0;
      tx_dat    <= '0;
    end else begin
      up <= 1'b1;
      if (bus.sft_rst_i) begin
        state     <= IDLE;
        idx       <= '0;
        pend_id   <= 1'b0;
        pend_meta <= 1'b0;
        paused    <= 1'b0;
        msk       <= '0;
        tx_vld    <= 1'b0;
        tx_dat    <= '0;
      end else begin
        paused    <= pause_nxt;
        pend_id   <= pend_id | bus.id_i;
        pend_meta <= pend_meta | bus.rd_meta_i;
        case (state)
          IDLE: begin
            // An accepted sample was offered ready before any strobe this cycle.
            if (smpl_acc) begin
              state  <= SMPL;
              smpl_q <= bus.smpl_i;
              msk    <= bus.grp_en_i;
              tx_dat <= grp_byte(bus.smpl_i, bus.grp_en_i);
              tx_vld <= (|bus.grp_en_i) & ~pause_nxt;
            end else if (req_id) begin
              state   <= ID;
              pend_id <= 1'b0;
              idx     <= '0;
              tx_dat  <= id_byte(2'd0);
              tx_vld  <= ~pause_nxt;
            end else if (req_meta) begin
              state     <= META;
              pend_meta <= 1'b0;
              idx       <= '0;
              tx_dat    <= rom_byte;
              tx_vld    <= ~pause_nxt;
            end
          end
          ID, META: begin
            if (xfer && last) begin
              state  <= IDLE;
              idx    <= '0;
              tx_vld <= 1'b0;
            end else if (xfer || !tx_vld) begin
              idx    <= nidx;
              tx_dat <= seq_byte;
              tx_vld <= ~pause_nxt;
            end
          end
          SMPL: begin
            if (msk_rem == 4'd0) begin
              state  <= IDLE;
              msk    <= '0;
              tx_vld <= 1'b0;
            end else if (xfer || !tx_vld) begin
              msk    <= msk_rem;
              tx_dat <= grp_byte(smpl_q, msk_rem);
              tx_vld <= ~pause_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.smpl_rdy_o = smpl_rdy;
  assign bus.tx_vld_o   = tx_vld;
  assign bus.tx_dat_o   = tx_dat;
  assign bus.busy_o     = (state != IDLE) | pend_id | pend_meta;

endmodule

// File: tb/tb_sump_resp_tx.sv
// Self-checking bench for sump_resp_tx: vector table, directed corner cases
// and randomized traffic against a byte-stream reference model.
module tb_sump_resp_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sump_resp_tx_if bus ();

  sump_resp_tx #(
    .NUM_PROBES (32),
    .MEM_DEPTH  (4096),
    .MAX_RATE   (100_000_000)
  ) dut (
    .clk_i  (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int vecs = 0;
  int errs = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] id_ref[$];
  logic [7:0] meta_ref[$];

  logic       prev_vld = 1'b0, prev_rdy = 1'b0, prev_sft = 1'b0, prev_rstn = 1'b0;
  logic [7:0] prev_dat = '0;

  typedef struct {
    int          kind;   // 0 id, 1 meta, 2 sample
    logic [3:0]  grp;
    logic [31:0] word;
    int          n;
    logic [7:0]  b0, b1, bl;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Advance one cycle; capture transfers and check held bytes at the negedge.
  task automatic step();
    @(negedge clk);
    if (prev_vld && !prev_rdy && !prev_sft && prev_rstn && rst_n) begin
      chk("hold_vld", 32'(bus.tx_vld_o), 32'd1);
      chk("hold_dat", 32'(bus.tx_dat_o), 32'(prev_dat));
    end
    if (rst_n && bus.tx_vld_o && bus.tx_rdy_i) got.push_back(bus.tx_dat_o);
    prev_vld  = bus.tx_vld_o;
    prev_rdy  = bus.tx_rdy_i;
    prev_sft  = bus.sft_rst_i;
    prev_rstn = rst_n;
    prev_dat  = bus.tx_dat_o;
    @(posedge clk);
    #1;
  endtask

  // mode 0: hold inputs, 1: random ready/pause, 2: toggle ready
  task automatic wait_idle(input int budget, input int mode);
    int n = 0;
    while ((bus.busy_o || bus.tx_vld_o) && n < budget) begin
      if (mode == 1) begin
        bus.tx_rdy_i = ($urandom_range(0, 3) != 0);
        bus.xoff_i   = ($urandom_range(0, 15) == 0);
        bus.xon_i    = ($urandom_range(0, 3) == 0);
      end else if (mode == 2) begin
        bus.tx_rdy_i = ~bus.tx_rdy_i;
      end
      step();
      n++;
    end
    bus.xoff_i = 1'b0;
    bus.xon_i  = 1'b0;
    bus.tx_rdy_i = 1'b1;
    chk("idle_within_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic cmp_stream(input string nm);
    int m;
    chk({nm, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_b%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic push_be(input logic [31:0] v);
    for (int k = 3; k >= 0; k--) meta_ref.push_back(v[8*k +: 8]);
  endtask

  task automatic clr_in();
    bus.sft_rst_i = 0; bus.id_i = 0; bus.rd_meta_i = 0; bus.xon_i = 0; bus.xoff_i = 0;
    bus.grp_en_i = '0; bus.smpl_vld_i = 0; bus.smpl_i = '0;
  endtask

  initial begin
    string nm_s;
    string id_s;
    logic [31:0] w;
    logic [3:0]  g;
    int          kind, sz;

    // Reference streams from the protocol description.
    id_s = "1ALS";
    for (int i = 0; i < 4; i++) id_ref.push_back(id_s[i]);
    nm_s = "logIP";
    meta_ref.push_back(8'h01);
    for (int i = 0; i < 5; i++) meta_ref.push_back(nm_s[i]);
    meta_ref.push_back(8'h00);
    meta_ref.push_back(8'h20); push_be(32);
    meta_ref.push_back(8'h21); push_be(4096 * 4);
    meta_ref.push_back(8'h23); push_be(100_000_000);
    meta_ref.push_back(8'h24); push_be(2);
    meta_ref.push_back(8'h00);

    tbl[0] = '{0, 4'h0, 32'h0,         4,  8'h31, 8'h41, 8'h53};
    tbl[1] = '{1, 4'h0, 32'h0,         28, 8'h01, 8'h6C, 8'h00};
    tbl[2] = '{2, 4'h5, 32'hA1B2_C3D4, 2,  8'hD4, 8'hB2, 8'hB2};
    tbl[3] = '{2, 4'h0, 32'hA1B2_C3D4, 0,  8'h00, 8'h00, 8'h00};
    tbl[4] = '{2, 4'hF, 32'h1234_5678, 4,  8'h78, 8'h56, 8'h12};
    tbl[5] = '{2, 4'h8, 32'hA1B2_C3D4, 1,  8'hA1, 8'hA1, 8'hA1};
    tbl[6] = '{2, 4'h6, 32'hA1B2_C3D4, 2,  8'hC3, 8'hB2, 8'hB2};

    clr_in();
    bus.tx_rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_vld", 32'(bus.tx_vld_o), 0);
    chk("rst_tx_dat", 32'(bus.tx_dat_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_smpl_rdy", 32'(bus.smpl_rdy_o), 0);
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_smpl_rdy", 32'(bus.smpl_rdy_o), 1);

    // Identify: first byte one cycle after the strobe, then back-to-back.
    got.delete();
    bus.id_i = 1; step(); bus.id_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("id_vld%0d", i), 32'(bus.tx_vld_o), 1);
      chk($sformatf("id_dat%0d", i), 32'(bus.tx_dat_o), 32'(id_ref[i]));
      step();
    end
    chk("id_end_vld", 32'(bus.tx_vld_o), 0);
    chk("id_end_busy", 32'(bus.busy_o), 0);

    for (int i = 0; i < 7; i++) begin
      got.delete();
      case (tbl[i].kind)
        0: bus.id_i = 1;
        1: bus.rd_meta_i = 1;
        default: begin
          bus.smpl_vld_i = 1; bus.smpl_i = tbl[i].word; bus.grp_en_i = tbl[i].grp;
        end
      endcase
      step();
      clr_in();
      chk($sformatf("t%0d_first_vld", i), 32'(bus.tx_vld_o), 32'(tbl[i].n > 0));
      wait_idle(200, 0);
      chk($sformatf("t%0d_count", i), 32'(got.size()), 32'(tbl[i].n));
      if (got.size() == tbl[i].n && tbl[i].n > 0) begin
        chk($sformatf("t%0d_first", i), 32'(got[0]), 32'(tbl[i].b0));
        chk($sformatf("t%0d_last", i), 32'(got[tbl[i].n-1]), 32'(tbl[i].bl));
        if (tbl[i].n > 1) chk($sformatf("t%0d_second", i), 32'(got[1]), 32'(tbl[i].b1));
      end
      chk($sformatf("t%0d_rdy_back", i), 32'(bus.smpl_rdy_o), 1);
    end

    // Metadata with ready toggling every cycle.
    got.delete();
    bus.rd_meta_i = 1; step(); bus.rd_meta_i = 0;
    wait_idle(300, 2);
    exp_q = meta_ref;
    cmp_stream("meta_toggle");

    // Simultaneous requests, repeated metadata strobe mid-identify.
    got.delete();
    bus.id_i = 1; bus.rd_meta_i = 1; step(); clr_in();
    step(); step();
    bus.rd_meta_i = 1; step(); bus.rd_meta_i = 0;
    wait_idle(300, 0);
    exp_q = id_ref;
    foreach (meta_ref[i]) exp_q.push_back(meta_ref[i]);
    cmp_stream("id_meta");

    // XOFF while byte 5 is stalled.
    got.delete();
    bus.rd_meta_i = 1; step(); bus.rd_meta_i = 0;
    repeat (5) step();
    bus.tx_rdy_i = 0; bus.xoff_i = 1;
    chk("xoff_b5_vld", 32'(bus.tx_vld_o), 1);
    chk("xoff_b5_dat", 32'(bus.tx_dat_o), 32'(meta_ref[5]));
    step(); bus.xoff_i = 0;
    repeat (3) step();
    chk("xoff_held_vld", 32'(bus.tx_vld_o), 1);
    bus.tx_rdy_i = 1;
    step();
    chk("xoff_drop_after_xfer", 32'(bus.tx_vld_o), 0);
    repeat (4) step();
    chk("xoff_still_paused", 32'(bus.tx_vld_o), 0);
    chk("xoff_count_paused", 32'(got.size()), 6);
    bus.xon_i = 1; step(); bus.xon_i = 0;
    chk("xon_resume", 32'(bus.tx_vld_o), 1);
    wait_idle(300, 0);
    exp_q = meta_ref;
    cmp_stream("xoff_meta");

    // Soft reset mid-metadata with an identify pending.
    got.delete();
    bus.rd_meta_i = 1; step(); bus.rd_meta_i = 0;
    repeat (3) step();
    bus.id_i = 1; step(); bus.id_i = 0;
    chk("sft_pending_busy", 32'(bus.busy_o), 1);
    bus.sft_rst_i = 1; step(); bus.sft_rst_i = 0;
    chk("sft_vld", 32'(bus.tx_vld_o), 0);
    chk("sft_busy", 32'(bus.busy_o), 0);
    sz = got.size();
    repeat (10) step();
    chk("sft_no_more_bytes", 32'(got.size()), 32'(sz));
    chk("sft_idle_busy", 32'(bus.busy_o), 0);

    // Randomized traffic against the reference byte stream.
    for (int t = 0; t < 40; t++) begin
      got.delete();
      exp_q.delete();
      kind = $urandom_range(0, 2);
      chk($sformatf("r%0d_rdy", t), 32'(bus.smpl_rdy_o), 1);
      if (kind == 0) begin
        bus.id_i = 1; exp_q = id_ref;
      end else if (kind == 1) begin
        bus.rd_meta_i = 1; exp_q = meta_ref;
      end else begin
        w = $urandom; g = 4'($urandom_range(0, 15));
        bus.smpl_vld_i = 1; bus.smpl_i = w; bus.grp_en_i = g;
        for (int k = 0; k < 4; k++) if (g[k]) exp_q.push_back(w[8*k +: 8]);
      end
      bus.tx_rdy_i = ($urandom_range(0, 3) != 0);
      bus.xoff_i   = ($urandom_range(0, 15) == 0);
      step();
      clr_in();
      wait_idle(3000, 1);
      cmp_stream($sformatf("rnd%0d", t));
    end

    // Asynchronous reset in the middle of a sequence.
    bus.xon_i = 1; step(); bus.xon_i = 0;
    got.delete();
    bus.id_i = 1; step(); bus.id_i = 0;
    step();
    #2;
    rst_n = 1'b0;
    prev_vld = 1'b0;
    #1;
    chk("arst_vld", 32'(bus.tx_vld_o), 0);
    chk("arst_dat", 32'(bus.tx_dat_o), 0);
    chk("arst_busy", 32'(bus.busy_o), 0);
    chk("arst_rdy", 32'(bus.smpl_rdy_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(); step();
    chk("arst_release_rdy", 32'(bus.smpl_rdy_o), 1);
    chk("arst_release_vld", 32'(bus.tx_vld_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
